// File: rtl/pipeline_pkg.sv
// Shared encodings and pipeline-register layouts for the memory/writeback end of the pipeline.
package pipeline_pkg;

  localparam int unsigned PL_DWIDTH = 32;
  localparam int unsigned PL_AWIDTH = 5;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;

  typedef struct packed {
    logic                 regWrite;
    logic [1:0]           resultSrc;
    logic                 memWrite;
    logic                 aType;
    logic [PL_DWIDTH-1:0] aluResult;
    logic [PL_DWIDTH-1:0] writeData;
    logic [PL_AWIDTH-1:0] rd;
    logic [PL_DWIDTH-1:0] pcPlus4;
  } ex_mem_t;

  typedef struct packed {
    logic                 regWrite;
    logic [1:0]           resultSrc;
    logic [PL_DWIDTH-1:0] aluResult;
    logic [PL_DWIDTH-1:0] readData;
    logic [PL_AWIDTH-1:0] rd;
    logic [PL_DWIDTH-1:0] pcPlus4;
  } mem_wb_t;

  function automatic logic [PL_DWIDTH-1:0] zeroExtendByte(input logic [7:0] b);
    return {{(PL_DWIDTH - 8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressed data RAM built from four byte-lane arrays: async word read, per-lane sync write.
module data_memory #(
  parameter int unsigned MEM_ADDR_BITS = 17
) (
  input  logic                     clk,
  input  logic [MEM_ADDR_BITS-3:0] wordAddr,
  input  logic [3:0]               laneWe,
  input  logic [31:0]              writeData,
  output logic [31:0]              readData
);

  localparam int unsigned Words = 2 ** (MEM_ADDR_BITS - 2);

  for (genvar g = 0; g < 4; g++) begin : gLane
    logic [7:0] mem [Words];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
      if (laneWe[g]) begin
        mem[wordAddr] <= writeData[8*g +: 8];
      end
    end

    assign readData[8*g +: 8] = mem[wordAddr];
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// EX/MEM register, data RAM access with lane select, MEM/WB register and writeback mux.
module memory_writeback_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned D_WIDTH       = 32,
  parameter int unsigned A_WIDTH       = 5,
  parameter int unsigned MEM_ADDR_BITS = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteE,
  input  logic [1:0]         ResultSrcE,
  input  logic               MemWriteE,
  input  logic               ATypeE,
  input  logic [D_WIDTH-1:0] ALUResultE,
  input  logic [D_WIDTH-1:0] WriteDataE,
  input  logic [A_WIDTH-1:0] RdE,
  input  logic [D_WIDTH-1:0] PCplus4E,
  output logic               RegWriteM,
  output logic [A_WIDTH-1:0] RdM,
  output logic [D_WIDTH-1:0] ALUResultM,
  output logic               MisalignM,
  output logic               RegWriteW,
  output logic [A_WIDTH-1:0] RdW,
  output logic [D_WIDTH-1:0] ResultW
);

  ex_mem_t exMem;
  mem_wb_t memWb;

  logic [MEM_ADDR_BITS-1:0] addrM;
  logic [1:0]               byteOff;
  logic                     accessM;
  logic [3:0]               laneWe;
  logic [31:0]              storeData;
  logic [31:0]              readWord;
  logic [31:0]              loadData;
  logic                     unusedUpperAddr;

  // Upper address bits wrap modulo the RAM size.
  assign addrM           = exMem.aluResult[MEM_ADDR_BITS-1:0];
  assign byteOff         = addrM[1:0];
  assign unusedUpperAddr = ^exMem.aluResult[D_WIDTH-1:MEM_ADDR_BITS];

  assign accessM   = exMem.memWrite || (exMem.resultSrc == RES_MEM);
  assign MisalignM = (exMem.aType == ACC_WORD) && accessM && (byteOff != 2'b00);

  always_comb begin
    laneWe    = 4'b0000;
    storeData = exMem.writeData;
    if (exMem.memWrite && !MisalignM) begin
      if (exMem.aType == ACC_BYTE) begin
        laneWe    = 4'b0001 << byteOff;
        storeData = {4{exMem.writeData[7:0]}};
      end else begin
        laneWe = 4'b1111;
      end
    end
  end

  data_memory #(
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) uDataMemory (
    .clk      (clk),
    .wordAddr (addrM[MEM_ADDR_BITS-1:2]),
    .laneWe   (laneWe),
    .writeData(storeData),
    .readData (readWord)
  );

  // Misaligned word loads simply return the aligned-down word.
  always_comb begin
    if (exMem.aType == ACC_BYTE) begin
      loadData = zeroExtendByte(readWord[8*byteOff +: 8]);
    end else begin
      loadData = readWord;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exMem <= '0;
      memWb <= '0;
    end else begin
      exMem.regWrite  <= RegWriteE;
      exMem.resultSrc <= ResultSrcE;
      exMem.memWrite  <= MemWriteE;
      exMem.aType     <= ATypeE;
      exMem.aluResult <= ALUResultE;
      exMem.writeData <= WriteDataE;
      exMem.rd        <= RdE;
      exMem.pcPlus4   <= PCplus4E;

      memWb.regWrite  <= exMem.regWrite;
      memWb.resultSrc <= exMem.resultSrc;
      memWb.aluResult <= exMem.aluResult;
      memWb.readData  <= loadData;
      memWb.rd        <= exMem.rd;
      memWb.pcPlus4   <= exMem.pcPlus4;
    end
  end

  assign RegWriteM  = exMem.regWrite;
  assign RdM        = exMem.rd;
  assign ALUResultM = exMem.aluResult;

  assign RegWriteW = memWb.regWrite;
  assign RdW       = memWb.rd;

  // Reserved encoding 11 falls back to the ALU result.
  always_comb begin
    case (memWb.resultSrc)
      RES_MEM: ResultW = memWb.readData;
      RES_PC4: ResultW = memWb.pcPlus4;
      default: ResultW = memWb.aluResult;
    endcase
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Scoreboard bench: stimulus queues expected writebacks and M-stage misalign flags; a monitor checks.
module tb_memory_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWriteE = 1'b0;
  logic [1:0]  ResultSrcE = 2'b00;
  logic        MemWriteE = 1'b0;
  logic        ATypeE = 1'b0;
  logic [31:0] ALUResultE = '0;
  logic [31:0] WriteDataE = '0;
  logic [4:0]  RdE = '0;
  logic [31:0] PCplus4E = '0;
  logic        RegWriteM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic        MisalignM;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
  } wb_exp_t;

  wb_exp_t wQ[$];
  logic    mQ[$];
  int      nTests = 0;
  int      nFails = 0;

  memory_writeback_stage dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteE (RegWriteE),
    .ResultSrcE(ResultSrcE),
    .MemWriteE (MemWriteE),
    .ATypeE    (ATypeE),
    .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE),
    .RdE       (RdE),
    .PCplus4E  (PCplus4E),
    .RegWriteM (RegWriteM),
    .RdM       (RdM),
    .ALUResultM(ALUResultM),
    .MisalignM (MisalignM),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one instruction for one cycle; expectations are queued alongside it.
  task automatic issue(input logic rw, input logic [1:0] src, input logic mw, input logic at,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [31:0] expRes, input logic isMem,
                       input logic expMis);
    wb_exp_t e;
    RegWriteE  = rw;
    ResultSrcE = src;
    MemWriteE  = mw;
    ATypeE     = at;
    ALUResultE = alu;
    WriteDataE = wd;
    RdE        = rd;
    PCplus4E   = pc4;
    if (rw) begin
      e.rd  = rd;
      e.res = expRes;
      wQ.push_back(e);
    end
    @(posedge clk);
    #1;
    if (isMem) mQ.push_back(expMis);
  endtask

  task automatic bubble();
    issue(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic mis);
    issue(1'b0, 2'b00, 1'b1, 1'b0, a, d, 5'd0, 32'h0, 32'h0, 1'b1, mis);
  endtask

  task automatic sb(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 2'b00, 1'b1, 1'b1, a, d, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp,
                    input logic mis);
    issue(1'b1, 2'b01, 1'b0, 1'b0, a, 32'h0, rd, 32'h0, exp, 1'b1, mis);
  endtask

  task automatic lbu(input logic [31:0] a, input logic [4:0] rd, input logic [31:0] exp);
    issue(1'b1, 2'b01, 1'b0, 1'b1, a, 32'h0, rd, 32'h0, exp, 1'b1, 1'b0);
  endtask

  // Monitor: M-stage misalign flags and W-stage writebacks against the queues.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (mQ.size() > 0) check("misalignM", {31'b0, MisalignM}, {31'b0, mQ.pop_front()});
      if (RegWriteW) begin
        if (wQ.size() == 0) begin
          check("unexpected_writeback_rd", {27'b0, RdW}, 32'hFFFF_FFFF);
        end else begin
          e = wQ.pop_front();
          check("writeback_rd", {27'b0, RdW}, {27'b0, e.rd});
          check("writeback_result", ResultW, e.res);
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    // Reset held with random inputs: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      RegWriteE  = r[0];
      ResultSrcE = r[2:1];
      MemWriteE  = 1'b0;
      ATypeE     = r[3];
      ALUResultE = $urandom;
      WriteDataE = $urandom;
      RdE        = r[8:4];
      PCplus4E   = $urandom;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_RegWriteM", {31'b0, RegWriteM}, 32'h0);
    check("rst_RdM", {27'b0, RdM}, 32'h0);
    check("rst_ALUResultM", ALUResultM, 32'h0);
    check("rst_MisalignM", {31'b0, MisalignM}, 32'h0);
    check("rst_RegWriteW", {31'b0, RegWriteW}, 32'h0);
    check("rst_RdW", {27'b0, RdW}, 32'h0);
    check("rst_ResultW", ResultW, 32'h0);
    rst = 1'b0;

    // Latency: not visible in W after one edge, visible after two.
    issue(1'b1, 2'b00, 1'b0, 1'b0, 32'h55, 32'h0, 5'd3, 32'h0, 32'h55, 1'b0, 1'b0);
    check("lat_RdM", {27'b0, RdM}, 32'd3);
    check("lat_ALUResultM", ALUResultM, 32'h55);
    check("lat_RegWriteW_early", {31'b0, RegWriteW}, 32'h0);
    bubble();
    check("lat_RegWriteW", {31'b0, RegWriteW}, 32'h1);
    check("lat_ResultW", ResultW, 32'h55);

    // Store then immediate load to the same word.
    sw(32'h100, 32'hDEADBEEF, 1'b0);
    lw(32'h100, 5'd5, 32'hDEADBEEF, 1'b0);

    // Byte store merges into one lane only.
    sw(32'h100, 32'h11223344, 1'b0);
    sb(32'h101, 32'hFFFFFF5A);
    lbu(32'h101, 5'd6, 32'h0000005A);
    lw(32'h100, 5'd7, 32'h11225A44, 1'b0);

    // Misaligned word accesses.
    sw(32'h102, 32'h99999999, 1'b1);
    lw(32'h102, 5'd8, 32'h11225A44, 1'b1);
    lbu(32'h102, 5'd9, 32'h00000022);
    lw(32'h100, 5'd10, 32'h11225A44, 1'b0);

    // Address wrap-around.
    sw(32'h0002_0008, 32'hCAFEF00D, 1'b0);
    lw(32'h0000_0008, 5'd11, 32'hCAFEF00D, 1'b0);
    lw(32'hFFF0_0008, 5'd12, 32'hCAFEF00D, 1'b0);

    // Writeback mux sources and x0 passthrough.
    issue(1'b1, 2'b10, 1'b0, 1'b0, 32'h777, 32'h0, 5'd1, 32'h1004, 32'h1004, 1'b0, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 1'b0, 32'hABC, 32'h0, 5'd2, 32'h2000, 32'hABC, 1'b0, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 1'b0, 32'h33, 32'h0, 5'd0, 32'h0, 32'h33, 1'b0, 1'b0);

    // Reset while a store sits in M discards it.
    sw(32'h200, 32'h12345678, 1'b0);
    bubble();
    bubble();
    bubble();
    sw(32'h200, 32'h0BADF00D, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_RegWriteW", {31'b0, RegWriteW}, 32'h0);
    check("midrst_ALUResultM", ALUResultM, 32'h0);
    rst = 1'b0;
    lw(32'h200, 5'd13, 32'h12345678, 1'b0);

    for (int i = 0; i < 4; i++) bubble();
    check("scoreboard_drained", wQ.size(), 32'd0);
    check("misalign_queue_drained", mQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
